// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the IF/MEM memory arbiter.
package arm_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {GNT_IF, GNT_MEM} arb_grant_t;
  localparam int ARB_CNT_W = 4;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter with a zero flag that times each memory access.
module mem_wait_counter
  import arm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ARB_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);
  logic [ARB_CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: shares one single-port memory between IF and MEM with fixed wait cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed MEM priority.
module mem_arbiter_ctrl
  import arm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_rdata
);
  arb_state_t state, state_nx;
  arb_grant_t gnt_q, gnt_nx;
  logic we_q, mem_req, grant, cnt_zero, unused_addr_lsb;
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign mem_req = mem_rd_en | mem_wr_en;
  assign grant = state == IDLE && (mem_req || if_req);
  assign unused_addr_lsb = ^{if_addr[1:0], mem_addr[1:0]};
`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_grant_t last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= GNT_IF;
    else if (grant) last_q <= gnt_nx;
  assign gnt_nx = (mem_req && if_req) ? (last_q == GNT_IF ? GNT_MEM : GNT_IF) : (mem_req ? GNT_MEM : GNT_IF);
`else
  assign gnt_nx = mem_req ? GNT_MEM : GNT_IF;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? (cnt_zero ? DONE : ACCESS) : IDLE;
    ram_we = state == ACCESS && we_q;
    ram_oe = state == ACCESS && !we_q;
    if_ready = state == DONE && gnt_q == GNT_IF;
    mem_ready = state == DONE && gnt_q == GNT_MEM;
    freeze = rst && mem_req && !mem_ready;
  end
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
  mem_wait_counter u_cnt (
    .clk,
    .rst,
    .load(grant),
    .load_val(ARB_CNT_W'(WAIT_CYCLES - 1)),
    .dec(state == ACCESS),
    .zero(cnt_zero)
  );
  // The granted request is latched so input changes during ACCESS cannot disturb it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gnt_q <= GNT_IF;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
    end else begin
      if (grant) begin
        gnt_q <= gnt_nx;
        we_q <= gnt_nx == GNT_MEM && mem_wr_en;
        addr_q <= gnt_nx == GNT_MEM ? mem_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        wdata_q <= mem_wdata;
      end
      if (state == ACCESS && cnt_zero && !we_q) begin
        if (gnt_q == GNT_IF) if_rdata <= ram_rdata;
        else mem_rdata <= ram_rdata;
      end
    end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: scoreboard bench with a transaction-level model of the shared memory.
module tb_mem_arbiter_ctrl;
  localparam int W = 3;
  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;
  logic clk = 0, rst = 0;
  logic if_req = 0, mem_rd_en = 0, mem_wr_en = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic [29:0] ram_addr;
  logic if_ready, mem_ready, freeze, ram_we, ram_oe;
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_if = 0, last_mem = 0;
  bit last_mem_gnt = 0;
  exp_t sbq[$];
  exp_t e;
  int cyc = 0, ntest = 0, nfail = 0;

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return i == 2 ? 32'hE3A0_0001 : 32'h5A00_0000 ^ (i * 32'h0101_0003);
  endfunction

  // Memory model: content is only visible while ram_oe is high.
  assign ram_rdata = ram_oe ? ram[ram_addr[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clk)
    if (cyc == 0) for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    else if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (if_ready || mem_ready) begin
      if (sbq.size() == 0) chk("unexpected_ready", {30'b0, if_ready, mem_ready}, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("ready_who", {30'b0, if_ready, mem_ready}, e.is_mem ? 32'd1 : 32'd2);
        chk("ready_cycle", cyc, e.due);
        chk(e.is_mem ? "mem_rdata" : "if_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
      end
    end

  // kind: 0 IF only, 1 MEM only, 2 both; op: {write, read}. Called at the start of an IDLE cycle.
  task automatic run_round(input int kind, input logic [1:0] op, input logic [31:0] ia, input logic [31:0] ma,
                           input logic [31:0] wd);
    bit do_if, do_mem, mem_w, two, mem_first, acc1, acc2, slot_mem, m;
    int start, mem_due, if_due, last_k;
    logic [31:0] iw, mw;
    do_if = kind != 1;
    do_mem = kind != 0;
    mem_w = op[1];
    two = do_if && do_mem;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_first = two ? !last_mem_gnt : do_mem;
`else
    mem_first = do_mem;
`endif
    iw = ia >> 2;
    mw = ma >> 2;
    mem_due = (two && !mem_first) ? 2 * W + 3 : W + 1;
    if_due = (two && mem_first) ? 2 * W + 3 : W + 1;
    last_k = two ? 2 * W + 3 : W + 1;
    start = cyc;
    rst = 1;
    if_req = do_if;
    if_addr = ia;
    mem_rd_en = do_mem & op[0];
    mem_wr_en = do_mem & op[1];
    mem_addr = ma;
    mem_wdata = wd;
    for (int s = 0; s < 2; s++) begin
      if (s == 0 || two) begin
        m = (s == 0) ? mem_first : !mem_first;
        if (m) begin
          if (mem_w) ref_mem[mw[7:0]] = wd;
          else last_mem = ref_mem[mw[7:0]];
          sbq.push_back('{1'b1, last_mem, start + (s == 0 ? W + 1 : 2 * W + 3)});
        end else begin
          last_if = ref_mem[iw[7:0]];
          sbq.push_back('{1'b0, last_if, start + (s == 0 ? W + 1 : 2 * W + 3)});
        end
        last_mem_gnt = m;
      end
    end
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      acc1 = k >= 1 && k <= W;
      acc2 = two && k >= W + 3 && k <= 2 * W + 2;
      slot_mem = acc1 ? mem_first : !mem_first;
      if (acc1 || acc2) begin
        chk("ram_we", {31'b0, ram_we}, {31'b0, slot_mem && mem_w});
        chk("ram_oe", {31'b0, ram_oe}, {31'b0, !(slot_mem && mem_w)});
        chk("ram_addr", {2'b0, ram_addr}, slot_mem ? mw : iw);
      end else begin
        chk("ram_we_idle", {31'b0, ram_we}, 32'd0);
        chk("ram_oe_idle", {31'b0, ram_oe}, 32'd0);
      end
      chk("freeze", {31'b0, freeze}, {31'b0, do_mem && k < mem_due});
      if (do_mem && k == mem_due) begin
        mem_rd_en = 0;
        mem_wr_en = 0;
      end
      if (do_if && k == if_due) if_req = 0;
      if (do_mem && k >= (mem_first ? 1 : W + 3) && k < mem_due) begin
        mem_addr = $urandom;
        mem_wdata = $urandom;
      end
      if (do_if && k >= ((two && mem_first) ? W + 3 : 1) && k < if_due) if_addr = $urandom;
    end
    @(posedge clk);
    #1;
    chk("missed_ready", sbq.size(), 32'd0);
    sbq.delete();
  endtask

  initial begin
    int kind;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    if_req = 1;
    mem_wr_en = 1;
    mem_addr = 32'h40;
    mem_wdata = 32'h55;
    repeat (2) begin
      @(negedge clk);
      chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
      chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
      chk("rst_freeze", {31'b0, freeze}, 32'd0);
      chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
      chk("rst_ram_oe", {31'b0, ram_oe}, 32'd0);
      chk("rst_ram_addr", {2'b0, ram_addr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    run_round(0, 2'b00, 32'h8, 32'h0, 32'h0);
    chk("fetch_data", if_rdata, 32'hE3A0_0001);
    run_round(1, 2'b10, 32'h0, 32'h400, 32'h1234);
    run_round(2, 2'b01, 32'h4, 32'h400, 32'h0);
    // Write aborted by reset in its second ACCESS cycle, then restarted with the request still held.
    if_req = 0;
    mem_rd_en = 0;
    mem_wr_en = 1;
    mem_addr = 32'h14;
    mem_wdata = 32'hCAFE_0005;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("pre_reset_we", {31'b0, ram_we}, 32'd1);
    rst = 0;
    #1;
    chk("async_rst_we", {31'b0, ram_we}, 32'd0);
    chk("async_rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("async_rst_freeze", {31'b0, freeze}, 32'd0);
    chk("async_rst_addr", {2'b0, ram_addr}, 32'd0);
    last_if = 0;
    last_mem = 0;
    last_mem_gnt = 0;
    @(posedge clk);
    #1;
    run_round(1, 2'b10, 32'h0, 32'h14, 32'hCAFE_0005);
    repeat (60) begin
      kind = $urandom_range(0, 2);
      run_round(kind, 2'($urandom_range(1, 3)), ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                ($urandom_range(0, 15) << 2) | $urandom_range(0, 3), $urandom);
    end
    for (int i = 0; i < 16; i++) chk("ram_contents", ram[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Sequencing controller that shares one single-port, word-wide instruction/data memory between the IF stage (instruction fetch) and the MEM stage (LDR/STR) of the ARM pipeline. It grants one requester at a time and drives the memory for a fixed number of wait cycles. It returns data with a one-cycle ready pulse and raises a pipeline-wide freeze while a data access is pending. It sits between the IF/MEM stage logic and the memory model, below the stage registers.

## Interface
- `ADDR_W`, 32, byte-address width of requester addresses
- `DATA_W`, 32, word width
- `WAIT_CYCLES`, 3, memory access cycles per transfer; legal range is 1 to 15
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  instruction fetch request, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch byte address
- `if_rdata`  out  DATA_W  fetched instruction
- `if_ready`  out  1  one-cycle completion pulse for IF
- `mem_rd_en` / `mem_wr_en`  in  1  data read / write request, held until `mem_ready`
- `mem_addr`  in  ADDR_W  data byte address
- `mem_wdata`  in  DATA_W  store data
- `mem_rdata`  out  DATA_W  load data
- `mem_ready`  out  1  one-cycle completion pulse for MEM
- `freeze`  out  1  stall of all pipeline registers
- `ram_addr`  out  ADDR_W-2  memory word address
- `ram_wdata`  out  DATA_W  memory write data
- `ram_we` / `ram_oe`  out  1  memory write / output enable
- `ram_rdata`  in  DATA_W  memory read data, valid while `ram_oe` is high

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - A pending request is granted and its address, data and direction are latched.
  - The state then moves to ACCESS and the wait counter is loaded with `WAIT_CYCLES`-1.
- **Arbitration**
  - MEM has fixed priority over IF.
  - If both `mem_rd_en` and `mem_wr_en` are high, the request is treated as a write.
- **ACCESS**
  - `ram_addr` is the latched byte address shifted right by 2; bits [1:0] are ignored.
  - Writes: `ram_we`=1 and `ram_wdata` is the latched data, for all ACCESS cycles.
  - Reads: `ram_oe`=1 for all ACCESS cycles. `ram_rdata` is captured into the granted requester's rdata register on the last ACCESS cycle (counter==0).
  - The counter decrements every cycle; at 0 the state moves to DONE.
- **DONE**
  - The granted requester's ready is high for exactly this cycle.
  - The state always returns to IDLE, so a held request is never re-granted.
- **Data hold:** `if_rdata` and `mem_rdata` hold their last captured value until the next read for that requester.
- **freeze** = (`mem_rd_en` | `mem_wr_en`) & ~`mem_ready`. It is combinational and also covers the cycles MEM spends waiting behind an IF grant.
- Requests that drop before their grant are ignored. Inputs changing during ACCESS do not affect the access in flight.

## Timing
- **Reset:** every output is 0 and the state is IDLE. This applies asynchronously on `rst` low, including mid-ACCESS: `ram_we` drops immediately and no ready is issued.
- **Latency:** a request seen in IDLE in cycle 0 gives ACCESS in cycles 1..`WAIT_CYCLES` and ready in cycle `WAIT_CYCLES`+1.
- **Throughput:** one transfer per `WAIT_CYCLES`+2 cycles (IDLE and DONE each add one cycle).
- **Contention:** the loser waits and is granted in the IDLE cycle after the winner's DONE.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** a last-grant flop (reset value: IF) drives arbitration. On contention the requester not granted last wins, and the flop updates on every grant.
- **Undefined:** fixed MEM priority as described above, and no last-grant flop exists.

## Structure
- Shared package `arm_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE/ACCESS/DONE)
  - the grant enum `arb_grant_t` (GNT_IF/GNT_MEM)
  - the constant `ARB_CNT_W`=4
- One sub-module, `mem_wait_counter`: a loadable down-counter with a zero flag, instantiated once.

## Test plan
All scenarios use `WAIT_CYCLES`=3.
- **Reset:** hold `rst`=0 for 2 cycles with requests active -> all outputs 0, no ready pulse.
- **Fetch:** `if_req`=1, `if_addr`=0x0000_0008, memory returns 0xE3A0_0001 -> `ram_addr`=2, `ram_oe` high in cycles 1-3, `if_ready` only in cycle 4, `if_rdata`=0xE3A0_0001.
- **Store:** `mem_wr_en`=1, `mem_addr`=0x400, `mem_wdata`=0x0000_1234 -> `ram_addr`=0x100, `ram_we` high for exactly 3 cycles, `freeze` high in cycles 0-3 and low in cycle 4 with `mem_ready`=1.
- **Contention (default build):** IF read and MEM read both raised in cycle 0 -> `mem_ready` in cycle 4; IF granted in cycle 5; `if_ready` in cycle 9.
- **Reset mid-access:** `rst` low during the 2nd ACCESS cycle of a write -> `ram_we` low at once, no `mem_ready`, IDLE after release, and the still-held request restarts from a full 3-cycle ACCESS.
- **Round-robin build:** `MEM_ARB_ROUND_ROBIN_EN` defined, both requesters held continuously for three transfers -> grant order MEM, IF, MEM.
